m6502_flag_seq: RTL
===================

Name: m6502_flag_seq

Overview:
- Upstream control stage for the 6502 ALU flag logic.
- Takes one request to write any subset of the N, V, D, Z, C flags, then serialises it into edge pulses on the ALU's ten flag_x_set / flag_x_reset lines.
- The ALU acts on a flag line only on a low-to-high edge and honours one edge per clock, so this block pulses one line at a time, each pulse followed by a low gap.
- Used by SEC/CLC/SED/CLD/CLV micro-ops (single flag) and PLP/RTI (all five flags from the pulled P byte).

Parameters:
- HOLD_CYCLES, 1: clocks a selected line stays high per pulse (legal 1..15).
- GAP_CYCLES, 1: clocks all lines stay low after each pulse before the next (legal 1..15; 0 is illegal).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted on a clk edge where valid&ready
- req_mask  in  5  flags to write; bit0=C, 1=Z, 2=D, 3=V, 4=N
- req_value  in  5  target value per flag, same bit order; ignored where mask=0
- flag_c_set, flag_c_reset, flag_z_set, flag_z_reset, flag_d_set, flag_d_reset, flag_v_set, flag_v_reset, flag_n_set, flag_n_reset  out  1 each  pulse lines to ALU
- busy  out  1  high from the accept edge until done deasserts
- done  out  1  one-cycle pulse, sequence complete
- pending  out  5  flags not yet pulsed (debug/verification)

Behaviour:
- Reset values: all outputs registered. During reset, all flag lines, busy, done=0 and pending=0. req_ready is derived from state and is 1 in reset.
- Reset takes effect immediately, also mid-sequence: lines drop low, state goes to IDLE, captured mask and value are discarded.
- FSM states are IDLE, PULSE, GAP, DONE. req_ready=1 only in IDLE.
- IDLE:
  - On valid&ready, capture mask into pending and capture value.
  - If mask==0, go to DONE; otherwise go to PULSE with current flag = lowest set bit of pending.
- PULSE:
  - Exactly one line is high for HOLD_CYCLES clocks: flag_x_set if value[x]=1, flag_x_reset if value[x]=0.
  - Then go to GAP.
- GAP:
  - All ten lines low for GAP_CYCLES clocks.
  - On the final GAP clock, clear the current bit in pending.
  - If any bits remain, go to PULSE with the next lowest set bit; otherwise go to DONE.
- DONE: done=1 for one clock, busy=1, then IDLE.
- Pulse order is fixed ascending: C, Z, D, V, N.
- Invariants:
  - Never more than one flag line high in any cycle.
  - Every rising edge is preceded by at least one low cycle on that line.
- Latency, k = popcount(mask):
  - Accept edge to done high = k*(HOLD_CYCLES+GAP_CYCLES) + 1 clocks.
  - req_ready returns 1 the clock after done.
  - k=0 gives done in the cycle after accept.
- Requests while busy are not accepted. The requester holds valid, mask and value until ready. Inputs are sampled only at the accept edge; later changes have no effect.
- Back-to-back requests: a request held through DONE is accepted on the first IDLE edge. The lines were already low during GAP, so edge spacing is preserved.
- pending equals the captured mask at the first PULSE, loses one bit per flag, and is 0 in DONE and IDLE.
- The down-counter for HOLD/GAP is 4 bits; it reloads on every state entry.

Test Plan:
- SEC: mask=00001, value=00001, defaults -> flag_c_set high exactly 1 clock starting 1 clock after accept; all other lines 0; done 3 clocks after accept; ready 4 clocks after.
- PLP with P=0xC3 (N=1,V=1,Z=1,C=1,D=0): mask=11111, value=11011 -> pulse order c_set, z_set, d_reset, v_set, n_set, each 1 high + 1 low; done at clock 11; pending steps 11111,11110,11100,11000,10000,00000.
- Empty request: mask=00000 -> no line toggles; done 1 clock after accept; busy high 1 clock.
- HOLD_CYCLES=3, GAP_CYCLES=2, mask=01010, value=00000 -> flag_z_reset high 3, all low 2, flag_v_reset high 3, low 2; done at clock 11.
- Reset asserted mid-PULSE of a 5-flag request -> lines, busy, done and pending go low asynchronously; after release ready=1 and a new SEC behaves as scenario 1.
- Back-to-back with valid held high and inputs changed while busy -> second request is accepted the clock after done, with the values present at that accept edge; the first request is unaffected by the changes; the one-line-high invariant is checked every cycle.

Source files
------------

// File: rtl/m6502_flag_seq.sv
// Serialises one N/V/D/Z/C flag-write request into single-line edge pulses for the ALU.
// Each pulse is HOLD_CYCLES high followed by GAP_CYCLES with every line low, in order C, Z, D, V, N.
module m6502_flag_seq #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_mask,
    input  logic [4:0] req_value,
    output logic       flag_c_set,
    output logic       flag_c_reset,
    output logic       flag_z_set,
    output logic       flag_z_reset,
    output logic       flag_d_set,
    output logic       flag_d_reset,
    output logic       flag_v_set,
    output logic       flag_v_reset,
    output logic       flag_n_set,
    output logic       flag_n_reset,
    output logic       busy,
    output logic       done,
    output logic [4:0] pending
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GapLoad  = 4'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  pending_q, pending_d;
    logic [4:0]  value_q, value_d;
    logic [9:0]  lines_q, lines_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [4:0]  cur_onehot;
    logic [4:0]  next_onehot;
    logic [4:0]  pending_cleared;

    // Lowest set bit of pending selects the flag currently being pulsed.
    assign cur_onehot      = pending_q & (~pending_q + 5'd1);
    assign pending_cleared = pending_q & ~cur_onehot;
    assign next_onehot     = pending_d & (~pending_d + 5'd1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        value_d   = value_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    pending_d = req_mask;
                    value_d   = req_value;
                    if (req_mask == 5'b00000) begin
                        state_d = StDone;
                    end else begin
                        state_d = StPulse;
                        cnt_d   = HoldLoad;
                    end
                end
            end
            StPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StGap;
                    cnt_d   = GapLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StGap: begin
                if (cnt_q == 4'd0) begin
                    pending_d = pending_cleared;
                    if (pending_cleared != 5'b00000) begin
                        state_d = StPulse;
                        cnt_d   = HoldLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        lines_d = 10'b0;
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        if (state_d == StPulse) begin
            for (int i = 0; i < 5; i++) begin
                lines_d[2*i+1] = next_onehot[i] & value_d[i];
                lines_d[2*i]   = next_onehot[i] & ~value_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            pending_q <= 5'b00000;
            value_q   <= 5'b00000;
            lines_q   <= 10'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            value_q   <= value_d;
            lines_q   <= lines_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign busy         = busy_q;
    assign done         = done_q;
    assign pending      = pending_q;

    assign flag_c_reset = lines_q[0];
    assign flag_c_set   = lines_q[1];
    assign flag_z_reset = lines_q[2];
    assign flag_z_set   = lines_q[3];
    assign flag_d_reset = lines_q[4];
    assign flag_d_set   = lines_q[5];
    assign flag_v_reset = lines_q[6];
    assign flag_v_set   = lines_q[7];
    assign flag_n_reset = lines_q[8];
    assign flag_n_set   = lines_q[9];

endmodule
